// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - RV32I decode and operand-select stage feeding alu_unit
module ex_operand_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [31:0]           instr_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] rs1_data_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_i,
    input  logic                  flush_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [5:0]            alu_op_o,
    output logic [DATA_WIDTH-1:0] a_o,
    output logic [DATA_WIDTH-1:0] b_o,
    output logic [4:0]            rd_o,
    output logic                  rd_we_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  illegal_o
);

    // ALU operation codes shared with alu_unit
    localparam logic [5:0] OP_ALU_ADD  = 6'd0;
    localparam logic [5:0] OP_ALU_SUB  = 6'd1;
    localparam logic [5:0] OP_ALU_SLL  = 6'd2;
    localparam logic [5:0] OP_ALU_SLT  = 6'd3;
    localparam logic [5:0] OP_ALU_SLTU = 6'd4;
    localparam logic [5:0] OP_ALU_XOR  = 6'd5;
    localparam logic [5:0] OP_ALU_SRL  = 6'd6;
    localparam logic [5:0] OP_ALU_SRA  = 6'd7;
    localparam logic [5:0] OP_ALU_OR   = 6'd8;
    localparam logic [5:0] OP_ALU_AND  = 6'd9;

    // RV32I major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Maps funct3 (plus the SUB/SRA alternate bit) onto an ALU operation
    function automatic logic [5:0] f3_to_op(input logic [2:0] f3, input logic alt);
        logic [5:0] op;
        case (f3)
            3'b000:  op = alt ? OP_ALU_SUB : OP_ALU_ADD;
            3'b001:  op = OP_ALU_SLL;
            3'b010:  op = OP_ALU_SLT;
            3'b011:  op = OP_ALU_SLTU;
            3'b100:  op = OP_ALU_XOR;
            3'b101:  op = alt ? OP_ALU_SRA : OP_ALU_SRL;
            3'b110:  op = OP_ALU_OR;
            default: op = OP_ALU_AND;
        endcase
        return op;
    endfunction

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [4:0]            rd_idx;
    logic [DATA_WIDTH-1:0] imm_i;
    logic [DATA_WIDTH-1:0] imm_s;
    logic [DATA_WIDTH-1:0] imm_u;
    logic [DATA_WIDTH-1:0] shamt;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign rd_idx = instr_i[11:7];

    // I and S immediates sign-extend from bit 31; U-imm and shift amounts do not
    assign imm_i = DATA_WIDTH'($signed(instr_i[31:20]));
    assign imm_s = DATA_WIDTH'($signed({instr_i[31:25], instr_i[11:7]}));
    assign imm_u = DATA_WIDTH'({instr_i[31:12], 12'b0});
    assign shamt = DATA_WIDTH'(instr_i[24:20]);

    logic [5:0]            dec_op;
    logic [DATA_WIDTH-1:0] dec_a;
    logic [DATA_WIDTH-1:0] dec_b;
    logic                  dec_ill;
    logic                  dec_writes;
    logic                  dec_rd_we;

    // Decode the offered instruction; illegal encodings leave op=ADD, a=b=0
    always_comb begin
        dec_op     = OP_ALU_ADD;
        dec_a      = '0;
        dec_b      = '0;
        dec_ill    = 1'b0;
        dec_writes = 1'b1;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE ||
                    (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    dec_a  = rs1_data_i;
                    dec_b  = rs2_data_i;
                    dec_op = f3_to_op(funct3, funct7[5]);
                end else begin
                    dec_ill = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    // Shift-immediates: upper bits must be a valid funct7
                    if (funct7 == F7_BASE || (funct3 == 3'b101 && funct7 == F7_ALT)) begin
                        dec_a  = rs1_data_i;
                        dec_b  = shamt;
                        dec_op = f3_to_op(funct3, funct7[5]);
                    end else begin
                        dec_ill = 1'b1;
                    end
                end else begin
                    // Upper bits are immediate here, so no SUB alternate
                    dec_a  = rs1_data_i;
                    dec_b  = imm_i;
                    dec_op = f3_to_op(funct3, 1'b0);
                end
            end
            OPC_LUI: begin
                dec_b = imm_u;
            end
            OPC_AUIPC: begin
                dec_a = pc_i;
                dec_b = imm_u;
            end
            OPC_LOAD: begin
                dec_a = rs1_data_i;
                dec_b = imm_i;
            end
            OPC_STORE: begin
                dec_a      = rs1_data_i;
                dec_b      = imm_s;
                dec_writes = 1'b0;
            end
            OPC_JAL, OPC_JALR: begin
                // Link value pc+4 is produced by the ALU
                dec_a = pc_i;
                dec_b = DATA_WIDTH'(32'd4);
            end
            OPC_BRANCH: begin
                dec_a      = rs1_data_i;
                dec_b      = rs2_data_i;
                dec_op     = OP_ALU_SUB;
                dec_writes = 1'b0;
            end
            default: begin
                dec_ill = 1'b1;
            end
        endcase
        dec_rd_we = dec_writes && !dec_ill && (rd_idx != 5'd0);
    end

    logic                  valid_q;
    logic [5:0]            op_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [4:0]            rd_q;
    logic                  rd_we_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic                  ill_q;

    // Single-entry pipeline register can take a new entry whenever it is empty or draining
    assign ready_o = !valid_q || ready_i;

    // Pipeline register: reset, flush, load on transfer, or drain when consumed
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            op_q    <= OP_ALU_ADD;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= 5'd0;
            rd_we_q <= 1'b0;
            pc_q    <= RESET_PC;
            ill_q   <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            rd_we_q <= 1'b0;
        end else if (valid_i && ready_o) begin
            valid_q <= 1'b1;
            op_q    <= dec_op;
            a_q     <= dec_a;
            b_q     <= dec_b;
            rd_q    <= rd_idx;
            rd_we_q <= dec_rd_we;
            pc_q    <= pc_i;
            ill_q   <= dec_ill;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o   = valid_q;
    assign alu_op_o  = op_q;
    assign a_o       = a_q;
    assign b_o       = b_q;
    assign rd_o      = rd_q;
    assign rd_we_o   = rd_we_q;
    assign pc_o      = pc_q;
    assign illegal_o = ill_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - scoreboard bench for ex_operand_stage
module tb_ex_operand_stage;

    localparam logic [31:0] RST_PC = 32'hA5A5_0000;

    localparam logic [5:0] A_ADD  = 6'd0;
    localparam logic [5:0] A_SUB  = 6'd1;
    localparam logic [5:0] A_SLL  = 6'd2;
    localparam logic [5:0] A_SLT  = 6'd3;
    localparam logic [5:0] A_SLTU = 6'd4;
    localparam logic [5:0] A_XOR  = 6'd5;
    localparam logic [5:0] A_SRL  = 6'd6;
    localparam logic [5:0] A_SRA  = 6'd7;
    localparam logic [5:0] A_OR   = 6'd8;
    localparam logic [5:0] A_AND  = 6'd9;

    logic        clk = 1'b0;
    logic        rst_i, valid_i, ready_o, flush_i, valid_o, ready_i, rd_we_o, illegal_o;
    logic [31:0] instr_i, pc_i, rs1_data_i, rs2_data_i, a_o, b_o, pc_o;
    logic [5:0]  alu_op_o;
    logic [4:0]  rd_o;

    always #5 clk = ~clk;

    ex_operand_stage #(.DATA_WIDTH(32), .RESET_PC(RST_PC)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .instr_i(instr_i), .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i), .alu_op_o(alu_op_o),
        .a_o(a_o), .b_o(b_o), .rd_o(rd_o), .rd_we_o(rd_we_o), .pc_o(pc_o),
        .illegal_o(illegal_o)
    );

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   started  = 0;
    bit   chk_reset = 0;
    bit   chk_flush = 0;
    bit   exp_ready_s = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference decode written from the instruction-set rules
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] rs1, input logic [31:0] rs2);
        exp_t       e;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [5:0] f3_op [8];
        int         imm_i, imm_s;
        logic [31:0] imm_u;
        opc   = ins[6:0];
        f3    = ins[14:12];
        f7    = ins[31:25];
        f3_op = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
        imm_i = int'(ins[31:20]) - (ins[31] ? 4096 : 0);
        imm_s = int'({ins[31:25], ins[11:7]}) - (ins[31] ? 4096 : 0);
        imm_u = {ins[31:12], 12'h000};
        e.op = A_ADD; e.a = 0; e.b = 0; e.rd = ins[11:7]; e.we = 1; e.pc = pc; e.ill = 0;
        case (opc)
            7'b0110011: begin
                if (f7 == 7'h00) begin
                    e.a = rs1; e.b = rs2; e.op = f3_op[f3];
                end else if (f7 == 7'h20 && f3 == 3'd0) begin
                    e.a = rs1; e.b = rs2; e.op = A_SUB;
                end else if (f7 == 7'h20 && f3 == 3'd5) begin
                    e.a = rs1; e.b = rs2; e.op = A_SRA;
                end else e.ill = 1;
            end
            7'b0010011: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    if (f7 == 7'h00) begin
                        e.a = rs1; e.b = 32'(ins[24:20]); e.op = f3_op[f3];
                    end else if (f7 == 7'h20 && f3 == 3'd5) begin
                        e.a = rs1; e.b = 32'(ins[24:20]); e.op = A_SRA;
                    end else e.ill = 1;
                end else begin
                    e.a = rs1; e.b = imm_i; e.op = f3_op[f3];
                end
            end
            7'b0110111: e.b = imm_u;
            7'b0010111: begin e.a = pc; e.b = imm_u; end
            7'b0000011: begin e.a = rs1; e.b = imm_i; end
            7'b0100011: begin e.a = rs1; e.b = imm_s; e.we = 0; end
            7'b1101111, 7'b1100111: begin e.a = pc; e.b = 4; end
            7'b1100011: begin e.a = rs1; e.b = rs2; e.op = A_SUB; e.we = 0; end
            default: e.ill = 1;
        endcase
        if (e.ill || e.rd == 0) e.we = 0;
        return e;
    endfunction

    // Monitor: compare held outputs with the scoreboard head, then retire it
    always @(negedge clk) begin
        bit held;
        held = exp_q.size() != 0;
        if (started) begin
            if (chk_reset) begin
                chk("rst valid_o", 32'(valid_o), 0);
                chk("rst alu_op_o", 32'(alu_op_o), 32'(A_ADD));
                chk("rst a_o", a_o, 0);
                chk("rst b_o", b_o, 0);
                chk("rst rd_o", 32'(rd_o), 0);
                chk("rst rd_we_o", 32'(rd_we_o), 0);
                chk("rst pc_o", pc_o, RST_PC);
                chk("rst illegal_o", 32'(illegal_o), 0);
            end else begin
                chk("valid_o", 32'(valid_o), 32'(held));
                if (held) begin
                    chk("alu_op_o", 32'(alu_op_o), 32'(exp_q[0].op));
                    chk("a_o", a_o, exp_q[0].a);
                    chk("b_o", b_o, exp_q[0].b);
                    chk("rd_o", 32'(rd_o), 32'(exp_q[0].rd));
                    chk("rd_we_o", 32'(rd_we_o), 32'(exp_q[0].we));
                    chk("pc_o", pc_o, exp_q[0].pc);
                    chk("illegal_o", 32'(illegal_o), 32'(exp_q[0].ill));
                end
                if (chk_flush) chk("flush rd_we_o", 32'(rd_we_o), 0);
            end
            chk("ready_o", 32'(ready_o), 32'(!held || ready_i));
        end
        exp_ready_s = !held || ready_i;
        chk_reset = 0;
        chk_flush = 0;
        if (rst_i) begin
            exp_q.delete();
            chk_reset = 1;
            started   = 1;
        end else if (flush_i) begin
            exp_q.delete();
            chk_flush = 1;
        end else if (held && ready_i) begin
            void'(exp_q.pop_front());
        end
    end

    // Issue side: an accepted instruction pushes its expected result
    always @(negedge clk) begin
        #1;
        if (started && !rst_i && !flush_i && valid_i && exp_ready_s)
            exp_q.push_back(model(instr_i, pc_i, rs1_data_i, rs2_data_i));
    end

    task automatic cyc(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input bit rdy, input bit fl, input bit rs);
        @(posedge clk);
        #1;
        valid_i = v; instr_i = ins; pc_i = pc; rs1_data_i = r1; rs2_data_i = r2;
        ready_i = rdy; flush_i = fl; rst_i = rs;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opcs [10];
        logic [31:0] ins;
        int          k;
        opcs = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011,
                 7'b0100011, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0010011};
        ins = $urandom;
        if ($urandom_range(0, 7) != 0) begin
            ins[6:0] = opcs[$urandom_range(0, 9)];
            k = $urandom_range(0, 9);
            if (k < 5) ins[31:25] = 7'h00;
            else if (k < 9) ins[31:25] = 7'h20;
        end
        return ins;
    endfunction

    initial begin
        rst_i = 1; valid_i = 0; flush_i = 0; ready_i = 0;
        instr_i = 0; pc_i = 0; rs1_data_i = 0; rs2_data_i = 0;
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        // Directed sequence
        cyc(1, 32'h002081B3, 32'h0000_0000, 32'd1, 32'd1, 1, 0, 0);
        cyc(1, 32'h40435293, 32'h0000_0004, 32'hFFFF_F000, 32'd0, 1, 0, 0);
        cyc(1, 32'hFF000093, 32'h0000_0008, 32'h1234_5678, 32'd0, 1, 0, 0);
        cyc(1, 32'h00001117, 32'h0000_0100, 32'd0, 32'd0, 1, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc(1, 32'h00208133, 32'h0000_0104, 32'd5, 32'd6, 0, 0, 0);
        cyc(1, 32'h00208133, 32'h0000_0104, 32'd5, 32'd6, 1, 0, 0);
        cyc(1, 32'h00500093, 32'h0000_0108, 32'd0, 32'd0, 0, 0, 0);
        cyc(1, 32'h00A00113, 32'h0000_010C, 32'd0, 32'd0, 0, 0, 0);
        cyc(1, 32'h00A00113, 32'h0000_010C, 32'd0, 32'd0, 0, 1, 0);
        cyc(1, 32'hFFFF_FFFF, 32'h0000_0110, 32'hDEAD_BEEF, 32'h1, 1, 0, 0);
        cyc(1, 32'h022081B3, 32'h0000_0114, 32'd7, 32'd8, 1, 0, 0);
        cyc(1, 32'h0020A023, 32'h0000_0118, 32'd9, 32'd3, 1, 0, 0);
        cyc(1, 32'hFE208EE3, 32'h0000_011C, 32'd9, 32'd3, 1, 0, 0);
        cyc(1, 32'h002081B3, 32'h0000_0120, 32'd1, 32'd1, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        // Randomized traffic
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 9) < 7, rand_instr(), $urandom, $urandom, $urandom,
                $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                $urandom_range(0, 99) == 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        @(posedge clk);
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
